// File: rtl/booth_pkg.sv
// Shared types and constants for the sequential Booth multiplier.
// Optional build macro: RADIX4_EN selects radix-4 (modified Booth) recoding.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Largest legal WIDTH is 32, so at most 32 steps.
    localparam int MAX_STEPS = 32;
    localparam int CNT_W     = $clog2(MAX_STEPS) + 1;

    // Number of Booth steps needed for a given operand width.
    function automatic int steps(input int width);
`ifdef RADIX4_EN
        return (width + 1) / 2;
`else
        return width;
`endif
    endfunction

endpackage

// File: rtl/booth_seq_mult_if.sv
// Operand/product valid-ready bus for booth_seq_mult.
interface booth_seq_mult_if #(
    parameter int WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     multiplicand;
    logic [WIDTH-1:0]     multiplier;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output in_valid, multiplicand, multiplier, out_ready,
        input  in_ready, out_valid, product
    );

    modport slave (
        input  in_valid, multiplicand, multiplier, out_ready,
        output in_ready, out_valid, product
    );
endinterface

// File: rtl/booth_step.sv
// One combinational Booth iteration on {A,Q,q_1}: add/sub then arithmetic shift.
// Radix-2 by default; radix-4 (digits 0, +-M, +-2M, shift by 2) with RADIX4_EN.
module booth_step #(
    parameter int AW = 9,   // accumulator width
    parameter int QW = 8    // multiplier register width
) (
    input  logic [AW-1:0] i_a,
    input  logic [QW-1:0] i_q,
    input  logic          i_q_1,
    input  logic [AW-1:0] i_m,
    output logic [AW-1:0] o_a,
    output logic [QW-1:0] o_q,
    output logic          o_q_1
);
    logic [AW-1:0] w_sum;

`ifdef RADIX4_EN
    logic [AW-1:0] w_m2;
    assign w_m2 = {i_m[AW-2:0], 1'b0};

    // Modified Booth digit selection on {Q[1:0],q_1}.
    always_comb begin
        w_sum = i_a;
        case ({i_q[1:0], i_q_1})
            3'b001, 3'b010: w_sum = i_a + i_m;
            3'b011:         w_sum = i_a + w_m2;
            3'b100:         w_sum = i_a - w_m2;
            3'b101, 3'b110: w_sum = i_a - i_m;
            default:        w_sum = i_a;
        endcase
    end

    assign o_a   = {{2{w_sum[AW-1]}}, w_sum[AW-1:2]};
    assign o_q   = {w_sum[1:0], i_q[QW-1:2]};
    assign o_q_1 = i_q[1];
`else
    // Radix-2 Booth selection on {Q[0],q_1}.
    always_comb begin
        w_sum = i_a;
        case ({i_q[0], i_q_1})
            2'b10:   w_sum = i_a - i_m;
            2'b01:   w_sum = i_a + i_m;
            default: w_sum = i_a;
        endcase
    end

    assign o_a   = {w_sum[AW-1], w_sum[AW-1:1]};
    assign o_q   = {w_sum[0], i_q[QW-1:1]};
    assign o_q_1 = i_q[0];
`endif

endmodule

// File: rtl/booth_seq_mult.sv
// Sequential signed Booth multiplier, WIDTH x WIDTH -> 2*WIDTH, one step per clock.
// Optional build macro: RADIX4_EN (radix-4 recoding, ceil(WIDTH/2) steps).
module booth_seq_mult
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    booth_seq_mult_if.slave bus
);
    localparam int NSTEP = steps(WIDTH);
`ifdef RADIX4_EN
    localparam int AW = WIDTH + 2;
    localparam int QW = 2 * NSTEP;
`else
    localparam int AW = WIDTH + 1;
    localparam int QW = WIDTH;
`endif

    state_t               r_state;
    state_t               w_state_nxt;
    logic [AW-1:0]        r_a;
    logic [QW-1:0]        r_q;
    logic                 r_q_1;
    logic [AW-1:0]        r_m;
    logic [CNT_W-1:0]     r_cnt;
    logic [2*WIDTH-1:0]   r_product;

    logic [AW-1:0]        w_a_nxt;
    logic [QW-1:0]        w_q_nxt;
    logic                 w_q_1_nxt;
    logic                 w_last;
    logic [2*WIDTH-1:0]   w_prod;

    booth_step #(.AW(AW), .QW(QW)) u_step (
        .i_a   (r_a),
        .i_q   (r_q),
        .i_q_1 (r_q_1),
        .i_m   (r_m),
        .o_a   (w_a_nxt),
        .o_q   (w_q_nxt),
        .o_q_1 (w_q_1_nxt)
    );

    assign w_last = (r_cnt == CNT_W'(NSTEP - 1));
    // Product is the low 2*WIDTH bits of {A,Q} after the final step.
    assign w_prod = {w_a_nxt[2*WIDTH-QW-1:0], w_q_nxt};

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.product   = r_product;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state: accept in IDLE, run NSTEP steps, hold in DONE until taken.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.in_valid)  w_state_nxt = RUN;
            RUN:     if (w_last)        w_state_nxt = DONE;
            DONE:    if (bus.out_ready) w_state_nxt = IDLE;
            default:                    w_state_nxt = IDLE;
        endcase
    end

    // Datapath: load operands on accept, iterate in RUN, capture product on last step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a       <= '0;
            r_q       <= '0;
            r_q_1     <= 1'b0;
            r_m       <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_a   <= '0;
                        r_q   <= QW'($signed(bus.multiplier));
                        r_q_1 <= 1'b0;
                        r_m   <= AW'($signed(bus.multiplicand));
                        r_cnt <= '0;
                    end
                end
                RUN: begin
                    r_a   <= w_a_nxt;
                    r_q   <= w_q_nxt;
                    r_q_1 <= w_q_1_nxt;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) r_product <= w_prod;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_seq_mult.sv
// Directed bench for booth_seq_mult at WIDTH=4 and WIDTH=8.
module tb_booth_seq_mult;

`ifdef RADIX4_EN
    localparam int LAT4 = 2;
    localparam int LAT8 = 4;
`else
    localparam int LAT4 = 4;
    localparam int LAT8 = 8;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    booth_seq_mult_if #(.WIDTH(4)) if4 ();
    booth_seq_mult_if #(.WIDTH(8)) if8 ();

    booth_seq_mult #(.WIDTH(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
    booth_seq_mult #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));

    int n_vec = 0;
    int n_err = 0;

    // Full WIDTH=4 transaction; called and returns at a negedge.
    task automatic go4(input logic [3:0] m, input logic [3:0] q,
                       output logic [7:0] p, output int lat);
        if4.multiplicand = m;
        if4.multiplier   = q;
        if4.in_valid     = 1'b1;
        @(negedge clk);
        if4.in_valid = 1'b0;
        lat = 0;
        while (!if4.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        p = if4.product;
        if4.out_ready = 1'b1;
        @(negedge clk);
        if4.out_ready = 1'b0;
    endtask

    // WIDTH=8 accept: returns at the negedge right after the accept edge.
    task automatic start8(input logic [7:0] m, input logic [7:0] q);
        if8.multiplicand = m;
        if8.multiplier   = q;
        if8.in_valid     = 1'b1;
        @(negedge clk);
        if8.in_valid = 1'b0;
    endtask

    // Waits for out_valid, counting cycles and noting any in_ready while busy.
    task automatic wait8(output logic [15:0] p, output int lat, output bit rdy_bad);
        lat = 0;
        rdy_bad = 1'b0;
        while (!if8.out_valid && lat < 40) begin
            if (if8.in_ready !== 1'b0) rdy_bad = 1'b1;
            @(negedge clk);
            lat++;
        end
        if (if8.in_ready !== 1'b0) rdy_bad = 1'b1;
        p = if8.product;
    endtask

    task automatic take8();
        if8.out_ready = 1'b1;
        @(negedge clk);
        if8.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        if4.in_valid = 1'b0; if4.out_ready = 1'b0; if4.multiplicand = '0; if4.multiplier = '0;
        if8.in_valid = 1'b0; if8.out_ready = 1'b0; if8.multiplicand = '0; if8.multiplier = '0;
        rst_n = 1'b0;
        #12;
        n_vec++;
        if ({if8.in_ready, if8.out_valid} !== 2'b10) begin
            n_err++; $display("FAIL reset_hs8: got %b want 10", {if8.in_ready, if8.out_valid});
        end
        n_vec++;
        if (if8.product !== 16'h0000) begin
            n_err++; $display("FAIL reset_prod8: got %h want 0000", if8.product);
        end
        n_vec++;
        if ({if4.in_ready, if4.out_valid, if4.product} !== {2'b10, 8'h00}) begin
            n_err++; $display("FAIL reset_dut4: got %b %h want 10 00", {if4.in_ready, if4.out_valid}, if4.product);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_w4_vectors();
        logic [3:0] tm [3] = '{4'h9, 4'h8, 4'h8};
        logic [3:0] tq [3] = '{4'h6, 4'h8, 4'h7};
        logic [7:0] te [3] = '{8'hD6, 8'h40, 8'hC8};
        logic [7:0] p;
        int lat;
        for (int i = 0; i < 3; i++) begin
            go4(tm[i], tq[i], p, lat);
            n_vec++;
            if (p !== te[i] || lat != LAT4) begin
                n_err++;
                $display("FAIL w4_vec%0d: got %h lat %0d want %h lat %0d", i, p, lat, te[i], LAT4);
            end
        end
    endtask

    task automatic test_w8_vectors();
        logic [7:0]  tm [10] = '{8'd12, 8'h80, 8'h80, 8'd127, 8'hFF, 8'd0,  8'hF9,   8'd3,    8'd100,  8'h80};
        logic [7:0]  tq [10] = '{8'd11, 8'h80, 8'd127, 8'd127, 8'hFF, 8'hFB, 8'd6,   8'hFB,   8'hFD,   8'd1};
        logic [15:0] te [10] = '{16'h0084, 16'h4000, 16'hC080, 16'h3F01, 16'h0001,
                                 16'h0000, 16'hFFD6, 16'hFFF1, 16'hFED4, 16'hFF80};
        logic [15:0] p;
        int lat;
        bit rb;
        for (int i = 0; i < 10; i++) begin
            start8(tm[i], tq[i]);
            wait8(p, lat, rb);
            take8();
            n_vec++;
            if (p !== te[i] || lat != LAT8 || rb) begin
                n_err++;
                $display("FAIL w8_vec%0d: got %h lat %0d rdy_bad %0d want %h lat %0d rdy_bad 0",
                         i, p, lat, rb, te[i], LAT8);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] p;
        int lat;
        bit rb;
        bit unstable;
        start8(8'd5, 8'd5);
        wait8(p, lat, rb);
        n_vec++;
        if (p !== 16'h0019 || lat != LAT8) begin
            n_err++; $display("FAIL bp_first: got %h lat %0d want 0019 lat %0d", p, lat, LAT8);
        end
        unstable = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (if8.out_valid !== 1'b1 || if8.product !== 16'h0019 || if8.in_ready !== 1'b0)
                unstable = 1'b1;
        end
        n_vec++;
        if (unstable) begin
            n_err++; $display("FAIL bp_hold: got unstable output want held 0019");
        end
        // Release and present the next pair in the same cycle.
        if8.out_ready    = 1'b1;
        if8.multiplicand = 8'hFE;
        if8.multiplier   = 8'd9;
        if8.in_valid     = 1'b1;
        @(negedge clk);
        if8.out_ready = 1'b0;
        n_vec++;
        if ({if8.in_ready, if8.out_valid} !== 2'b10) begin
            n_err++; $display("FAIL b2b_idle: got %b want 10", {if8.in_ready, if8.out_valid});
        end
        @(negedge clk);
        if8.in_valid = 1'b0;
        n_vec++;
        if (if8.in_ready !== 1'b0) begin
            n_err++; $display("FAIL b2b_accept: got in_ready %b want 0", if8.in_ready);
        end
        wait8(p, lat, rb);
        take8();
        n_vec++;
        if (p !== 16'hFFEE || lat != LAT8 || rb) begin
            n_err++; $display("FAIL b2b_second: got %h lat %0d want FFEE lat %0d", p, lat, LAT8);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [15:0] p;
        int lat;
        bit rb;
        bit stale;
        start8(8'd50, 8'd50);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({if8.in_ready, if8.out_valid, if8.product} !== {2'b10, 16'h0000}) begin
            n_err++;
            $display("FAIL mid_reset: got %b %h want 10 0000", {if8.in_ready, if8.out_valid}, if8.product);
        end
        @(negedge clk);
        rst_n = 1'b1;
        stale = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (if8.out_valid !== 1'b0) stale = 1'b1;
        end
        n_vec++;
        if (stale) begin
            n_err++; $display("FAIL mid_reset_stale: got out_valid 1 want 0");
        end
        start8(8'd3, 8'hFB);
        wait8(p, lat, rb);
        take8();
        n_vec++;
        if (p !== 16'hFFF1 || lat != LAT8 || rb) begin
            n_err++; $display("FAIL post_reset_mul: got %h lat %0d want FFF1 lat %0d", p, lat, LAT8);
        end
    endtask

    task automatic test_operand_change();
        int lat;
        start8(8'd12, 8'd11);
        lat = 0;
        while (!if8.out_valid && lat < 40) begin
            if8.multiplicand = ~if8.multiplicand;
            if8.multiplier   = if8.multiplier + 8'd37;
            @(negedge clk);
            lat++;
        end
        n_vec++;
        if (if8.product !== 16'h0084 || lat != LAT8) begin
            n_err++; $display("FAIL op_change: got %h lat %0d want 0084 lat %0d", if8.product, lat, LAT8);
        end
        take8();
    endtask

    initial begin
        test_reset();
        test_w4_vectors();
        test_w8_vectors();
        test_back_to_back();
        test_reset_mid_run();
        test_operand_change();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
